// File: rtl/keyscan_pkg.sv
// ---------------------------------------------------------------------------
// | Module      : keyscan_pkg                                               |
// | Description : Shared types and default sizing for the keypad scanner.  |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

package keyscan_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      EMIT     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam int NROW_DEF     = 4;
   localparam int NCOL_DEF     = 4;
   localparam int DB_TICKS_DEF = 4;
   localparam int KEY_W        = $clog2(NROW_DEF * NCOL_DEF);

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
// ---------------------------------------------------------------------------
// | Module      : sync2                                                     |
// | Description : W-wide two-flop synchronizer; resets to all-ones so idle  |
// |               pulled-up lines read as "no key" straight out of reset.   |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module sync2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   // Next values of the two synchronizer stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer flops, asynchronously forced to the idle (all-high) level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// | Module      : keypad_scanner                                            |
// | Description : Column-scanning 4x4 keypad reader with press/release      |
// |               debounce and a valid/ready key-code output stream.        |
// | Config      : KEYSCAN_GHOST_REJECT_EN - multi-row hits never produce a  |
// |               code (default: lowest-index low row wins).                |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_scanner
   import keyscan_pkg::*;
#(
   parameter int NROW     = NROW_DEF,
   parameter int NCOL     = NCOL_DEF,
   parameter int DB_TICKS = DB_TICKS_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           tick,
   input  logic [NROW-1:0]                rows,
   output logic [NCOL-1:0]                cols,
   output logic                           key_valid,
   input  logic                           key_ready,
   output logic [$clog2(NROW*NCOL)-1:0]   key_code
);

   localparam int CODE_W = $clog2(NROW * NCOL);
   localparam int COL_W  = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam int ROW_W  = (NROW > 1) ? $clog2(NROW) : 1;
   localparam int DB_W   = $clog2(DB_TICKS + 1);

`ifdef KEYSCAN_GHOST_REJECT_EN
   localparam bit GHOST_REJECT = 1'b1;
`else
   localparam bit GHOST_REJECT = 1'b0;
`endif

   logic [NROW-1:0]   rows_s;
   logic              row_hit;
   logic              multi_hit;
   logic [ROW_W-1:0]  hit_row;
   logic              scan_hit;
   logic              still_low;
   logic [COL_W-1:0]  col_next;
   logic [DB_W-1:0]   db_inc;
   logic              db_done;

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DB_W-1:0]   db_q, db_d;
   logic              key_valid_q, key_valid_d;
   logic [CODE_W-1:0] key_code_q, key_code_d;

   sync2 #(.W(NROW)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rows_s)
   );

   // Row decode: any-low, lowest-index low row, and more-than-one-low.
   always_comb begin
      int low_cnt;
      low_cnt = 0;
      hit_row = '0;
      for (int i = NROW - 1; i >= 0; i--) begin
         if (!rows_s[i]) begin
            hit_row = ROW_W'(i);
            low_cnt = low_cnt + 1;
         end
      end
      row_hit   = (low_cnt != 0);
      multi_hit = (low_cnt > 1);
      scan_hit  = row_hit && !(GHOST_REJECT && multi_hit);
      still_low = scan_hit && (hit_row == row_q);
      col_next  = (col_q == COL_W'(NCOL - 1)) ? '0 : col_q + 1'b1;
      db_inc    = (db_q == DB_W'(DB_TICKS)) ? db_q : db_q + 1'b1;
      db_done   = (db_inc == DB_W'(DB_TICKS));
   end

   // Scan/debounce/emit/release sequencing; only the handshake acts between ticks.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      db_d        = db_q;
      key_valid_d = key_valid_q;
      key_code_d  = key_code_q;
      case (state_q)
         SCAN: begin
            if (tick) begin
               if (scan_hit) begin
                  state_d = DEBOUNCE;
                  row_d   = hit_row;
                  db_d    = DB_W'(1);
               end else begin
                  col_d = col_next;
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (still_low) begin
                  db_d = db_inc;
                  if (db_done) begin
                     state_d     = EMIT;
                     key_valid_d = 1'b1;
                     key_code_d  = CODE_W'(int'(row_q) * NCOL + int'(col_q));
                  end
               end else begin
                  state_d = SCAN;
                  col_d   = col_next;
                  db_d    = '0;
               end
            end
         end
         EMIT: begin
            if (key_valid_q && key_ready) begin
               state_d     = RELEASE;
               key_valid_d = 1'b0;
               db_d        = '0;
            end
         end
         RELEASE: begin
            if (tick) begin
               if (!row_hit) begin
                  db_d = db_inc;
                  if (db_done) begin
                     state_d = SCAN;
                     col_d   = col_next;
                     db_d    = '0;
                  end
               end else begin
                  db_d = '0;
               end
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase
   end

   // State and datapath registers; reset abandons any pending key.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_q       <= '0;
         row_q       <= '0;
         db_q        <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         db_q        <= db_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   // Active-low one-hot column drive from the column index.
   always_comb begin
      cols = '1;
      for (int i = 0; i < NCOL; i++) begin
         cols[i] = (col_q != COL_W'(i));
      end
   end

   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;

endmodule

`default_nettype wire
